// File: rtl/exp_pkg.sv
// exp_pkg: shared constants and types for the e^x shift-add sequencer.
//   X_W / Y_W / K_W : remainder (Q4.11), mantissa (Q2.14) and exponent widths
//   ITER_MAX        : maximum number of update steps per operand
//   LN2, Y_ONE      : ln(2) in Q4.11 and 1.0 in Q2.14
//   state_t         : sequencer states, also exported on the debug port
package exp_pkg;

  localparam int X_W      = 15;
  localparam int Y_W      = 16;
  localparam int K_W      = 5;
  localparam int I_W      = 5;
  localparam int ITER_MAX = 24;
  localparam int ITER_W   = 5;

  localparam logic [X_W-1:0] LN2   = 15'h058B;
  localparam logic [Y_W-1:0] Y_ONE = 16'h4000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    UPD  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/exp_ln_rom.sv
// exp_ln_rom: ln(1 + 2^-i) in Q4.11 for i = 1..11.
//   i_idx : table index (5 bits)
//   o_val : table constant; 0 for index 0 or any index above 11
// Also used by the selection block's threshold compare, so the zero
// return for out-of-range indices doubles as "no fractional step".
module exp_ln_rom
  import exp_pkg::*;
(
  input  logic [I_W-1:0] i_idx,
  output logic [X_W-1:0] o_val
);

  always_comb begin
    o_val = '0;
    case (i_idx)
      5'd1:    o_val = 15'd830;
      5'd2:    o_val = 15'd457;
      5'd3:    o_val = 15'd241;
      5'd4:    o_val = 15'd124;
      5'd5:    o_val = 15'd63;
      5'd6:    o_val = 15'd32;
      5'd7:    o_val = 15'd16;
      5'd8:    o_val = 15'd8;
      5'd9:    o_val = 15'd4;
      5'd10:   o_val = 15'd2;
      5'd11:   o_val = 15'd1;
      default: o_val = '0;
    endcase
  end

endmodule

// File: rtl/exp_ctrl.sv
// exp_ctrl: iterative shift-add sequencer computing e^x = y * 2^k.
//   clk, rst               : clock, synchronous active-high reset
//   in_valid/in_ready/in_x : operand handshake, x in Q4.11
//   sel_data               : current remainder r, to the external selection block
//   sel_i, sel_int_or_fra  : registered decision from selection for r
//   out_valid/out_ready    : result handshake
//   out_y, out_k, out_err  : mantissa (Q2.14), exponent, error flag
//   dbg_state              : current sequencer state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE, out_valid only in DONE; the
// result registers do not change while out_valid is high, and no new operand
// is accepted until the result has been taken.
module exp_ctrl
  import exp_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [X_W-1:0] in_x,
  output logic [X_W-1:0] sel_data,
  input  logic [I_W-1:0] sel_i,
  input  logic           sel_int_or_fra,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [Y_W-1:0] out_y,
  output logic [K_W-1:0] out_k,
  output logic           out_err,
  output state_t         dbg_state
);

  state_t              r_state, w_state_nx;
  logic [X_W-1:0]      r_r, w_r_nx;
  logic [Y_W-1:0]      r_y, w_y_nx;
  logic [K_W-1:0]      r_k, w_k_nx;
  logic [ITER_W-1:0]   r_iter, w_iter_nx;
  logic                r_err, w_err_nx;

  logic [X_W-1:0]      w_rom_val;
  logic [X_W-1:0]      w_sub;
  logic [Y_W-1:0]      w_y_inc;

  exp_ln_rom u_rom (
    .i_idx (sel_i),
    .o_val (w_rom_val)
  );

  assign w_sub   = sel_int_or_fra ? LN2 : w_rom_val;
  assign w_y_inc = r_y >> sel_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_r     <= '0;
      r_y     <= Y_ONE;
      r_k     <= '0;
      r_iter  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_r     <= w_r_nx;
      r_y     <= w_y_nx;
      r_k     <= w_k_nx;
      r_iter  <= w_iter_nx;
      r_err   <= w_err_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_r_nx     = r_r;
    w_y_nx     = r_y;
    w_k_nx     = r_k;
    w_iter_nx  = r_iter;
    w_err_nx   = r_err;

    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_r_nx     = in_x;
          w_y_nx     = Y_ONE;
          w_k_nx     = '0;
          w_iter_nx  = '0;
          w_err_nx   = 1'b0;
          w_state_nx = SEL;
        end
      end

      // Selection needs one edge to register its decision for the new r.
      SEL: w_state_nx = UPD;

      UPD: begin
        // A zero table value on the fractional path means index 0 or an
        // out-of-range index: the remainder is below every table entry.
        if (!sel_int_or_fra && (w_rom_val == '0)) begin
          w_state_nx = DONE;
        end else begin
          if (w_sub > r_r) begin
            w_r_nx   = '0;
            w_err_nx = 1'b1;
          end else begin
            w_r_nx = r_r - w_sub;
          end

          if (sel_int_or_fra) begin
            if (&r_k) begin
              w_err_nx = 1'b1;
            end else begin
              w_k_nx = r_k + 1'b1;
            end
          end else begin
            w_y_nx = r_y + w_y_inc;
          end

          w_iter_nx = r_iter + 1'b1;
          if (r_iter == ITER_W'(ITER_MAX - 1)) begin
            w_err_nx   = 1'b1;
            w_state_nx = DONE;
          end else begin
            w_state_nx = SEL;
          end
        end
      end

      DONE: begin
        if (out_ready) w_state_nx = IDLE;
      end

      default: w_state_nx = IDLE;
    endcase
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sel_data  = r_r;
  assign out_y     = r_y;
  assign out_k     = r_k;
  assign out_err   = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_exp_ctrl.sv
// tb_exp_ctrl: directed and randomized bench for exp_ctrl with a registered
// selection stand-in and an arithmetic reference model of the whole loop.
module tb_exp_ctrl;
  import exp_pkg::*;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [14:0]    in_x = '0;
  logic [14:0]    sel_data;
  logic [4:0]     sel_i;
  logic           sel_int_or_fra;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [15:0]    out_y;
  logic [4:0]     out_k;
  logic           out_err;
  state_t         dbg_state;

  int checks = 0;
  int errors = 0;
  int sel_mode = 0;
  int last_lat, last_y, last_k, last_err;
  logic [21:0] exp_q[$];

  int tab [12] = '{0, 830, 457, 241, 124, 63, 32, 16, 8, 4, 2, 1};

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  exp_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_x           (in_x),
    .sel_data       (sel_data),
    .sel_i          (sel_i),
    .sel_int_or_fra (sel_int_or_fra),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_y          (out_y),
    .out_k          (out_k),
    .out_err        (out_err),
    .dbg_state      (dbg_state)
  );

  // Selection decision for remainder r.
  //   mode 0/2: largest step that fits (ln2 first, then smallest i with tab[i] <= r)
  //   mode 1  : always the ln2 step
  //   mode 3  : one table entry too large, forcing remainder underflow
  function automatic logic [5:0] pick(input int r, input int mode);
    int g;
    if (mode == 1) return {1'b1, 5'd0};
    if (r >= 1419) return {1'b1, 5'd0};
    g = 0;
    for (int i = 1; i <= 11; i++)
      if (g == 0 && tab[i] <= r) g = i;
    if (mode == 3 && g > 1) g = g - 1;
    return {1'b0, 5'(g)};
  endfunction

  // Registered selection block; mode 2 reports "nothing fits" with an
  // out-of-range index instead of 0.
  logic [5:0] sel_d;
  always @(posedge clk) begin
    sel_d = pick(int'(sel_data), sel_mode);
    if (rst) begin
      sel_int_or_fra <= 1'b0;
      sel_i          <= '0;
    end else begin
      sel_int_or_fra <= sel_d[5];
      if (sel_mode == 2 && !sel_d[5] && sel_d[4:0] == 5'd0)
        sel_i <= 5'($urandom_range(12, 31));
      else
        sel_i <= sel_d[4:0];
    end
  end

  // Reference: e^x by repeated range reduction, counting update steps.
  task automatic model(input int x, input int mode,
                       output int ey, output int ek, output int eerr, output int en);
    int r, y, k, it, err, n, sub;
    logic [5:0] d;
    bit fin;
    r = x; y = 'h4000; k = 0; it = 0; err = 0; n = 0; fin = 0;
    while (!fin) begin
      n++;
      d = pick(r, mode);
      if (!d[5] && d[4:0] == 0) begin
        fin = 1;
      end else begin
        if (d[5]) begin
          sub = 1419;
          if (k == 31) err = 1; else k++;
        end else begin
          sub = tab[d[4:0]];
          y = (y + (y >> d[4:0])) & 'hFFFF;
        end
        if (sub > r) begin r = 0; err = 1; end else r = r - sub;
        it++;
        if (it == 24) begin err = 1; fin = 1; end
      end
    end
    ey = y; ek = k; eerr = err; en = n;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  1);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_y"},     32'(out_y),     32'h4000);
    check({tag, "_out_k"},     32'(out_k),     0);
    check({tag, "_out_err"},   32'(out_err),   0);
    check({tag, "_sel_data"},  32'(sel_data),  0);
    check({tag, "_state"},     32'(dbg_state), 32'(IDLE));
  endtask

  // ---------------- driver: one full operand ----------------
  task automatic run_op(input int x, input int mode, input int bp);
    int ey, ek, eerr, en, edges;
    logic [21:0] e;
    model(x, mode, ey, ek, eerr, en);
    exp_q.push_back({1'(eerr), 5'(ek), 16'(ey)});
    sel_mode = mode;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_x     = 15'(x);
    @(posedge clk);
    @(negedge clk);
    check("sel_data_latched", 32'(sel_data), 32'(x));
    check("in_ready_busy", 32'(in_ready), 0);
    edges = 0;
    while (!out_valid && edges < 300) begin
      in_valid = 1'($urandom_range(0, 1));
      in_x     = 15'($urandom);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    e = exp_q.pop_front();
    check("latency", 32'(edges), 32'(2 * en));
    check("out_y",   32'(out_y),   32'(e[15:0]));
    check("out_k",   32'(out_k),   32'(e[20:16]));
    check("out_err", 32'(out_err), 32'(e[21]));
    check("in_ready_done", 32'(in_ready), 0);
    for (int c = 0; c < bp; c++) begin
      in_valid = 1'b1;
      in_x     = 15'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_in_ready",  32'(in_ready),  0);
      check("bp_out_y",     32'(out_y),     32'(e[15:0]));
      check("bp_out_k",     32'(out_k),     32'(e[20:16]));
      check("bp_out_err",   32'(out_err),   32'(e[21]));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("release_out_valid", 32'(out_valid), 0);
    check("release_in_ready",  32'(in_ready),  1);
    last_lat = edges; last_y = int'(e[15:0]); last_k = int'(e[20:16]); last_err = int'(e[21]);
  endtask

  initial begin
    // ---------------- reset ----------------
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // x = 0: single terminating step
    run_op(0, 0, 0);
    check("x0_lat", 32'(last_lat), 2);
    check("x0_y",   32'(last_y),   32'h4000);
    check("x0_k",   32'(last_k),   0);
    check("x0_err", 32'(last_err), 0);

    // x = ln2: one exponent step
    run_op('h058B, 0, 0);
    check("ln2_lat", 32'(last_lat), 4);
    check("ln2_y",   32'(last_y),   32'h4000);
    check("ln2_k",   32'(last_k),   1);

    // x = ln(1.5): one mantissa step
    run_op('h033E, 0, 0);
    check("ln15_lat", 32'(last_lat), 4);
    check("ln15_y",   32'(last_y),   32'h6000);
    check("ln15_k",   32'(last_k),   0);

    // backpressure with extra in_valid while the result waits
    run_op('h0400, 0, 10);
    run_op('h0123, 0, 0);

    // ln2-only selection: underflow then iteration cap
    run_op('h7FFF, 1, 3);
    check("cap_lat", 32'(last_lat), 48);
    check("cap_k",   32'(last_k),   24);
    check("cap_err", 32'(last_err), 1);

    // reset while in UPD aborts the operand
    sel_mode = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_x     = 15'h033E;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_in_upd", 32'(dbg_state), 32'(UPD));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("abort");
    run_op('h033E, 0, 0);
    check("after_abort_y", 32'(last_y), 32'h6000);

    // randomized operands across selection behaviours
    for (int n = 0; n < 20; n++) run_op(int'($urandom_range(0, 'h7FFF)), 0, int'($urandom_range(0, 3)));
    for (int n = 0; n < 6; n++)  run_op(int'($urandom_range(0, 'h1FFF)), 2, int'($urandom_range(0, 2)));
    for (int n = 0; n < 6; n++)  run_op(int'($urandom_range(1, 'h0FFF)), 3, int'($urandom_range(0, 2)));
    for (int n = 0; n < 3; n++)  run_op(int'($urandom_range(0, 'h7FFF)), 1, 0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
